// File: rtl/operand_fetch_pkg.sv
// Shared constants and types for the operand-fetch pipeline stage.
package operand_fetch_pkg;

  localparam int XLEN           = 32;
  localparam int REG_AW         = 5;
  localparam int CTRL_W_DEFAULT = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } of_state_t;

endpackage

// File: rtl/of_bypass.sv
// Per-source operand select: writeback bypass, register-file data or zero,
// plus the hazard flag for a pending (dirty) source that cannot be bypassed.
module of_bypass
  import operand_fetch_pkg::*;
(
  input  logic              src_en,
  input  logic [REG_AW-1:0] src_addr,
  input  logic [XLEN-1:0]   rf_data,
  input  logic              rf_dirty,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   operand,
  output logic              hazard
);

  logic src_zero;
  logic bypass;

  // x0 and unused sources read as zero and never bypass or stall.
  assign src_zero = !src_en || (src_addr == '0);
  assign bypass   = wb_en && (wb_addr == src_addr) && (src_addr != '0);

  assign operand = src_zero ? '0 : (bypass ? wb_data : rf_data);
  assign hazard  = !src_zero && rf_dirty && !bypass;

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads sources, bypasses writeback, stalls on pending
// registers and holds the decoded instruction in a one-entry output register.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              in_rs1_en,
  input  logic              in_rs2_en,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic              in_rd_en,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,

  output logic              rf_rd0_en,
  output logic              rf_rd1_en,
  output logic [REG_AW-1:0] rf_rd0_addr,
  output logic [REG_AW-1:0] rf_rd1_addr,
  input  logic [XLEN-1:0]   rf_rd0_data,
  input  logic [XLEN-1:0]   rf_rd1_data,
  input  logic              rf_rd0_dirty,
  input  logic              rf_rd1_dirty,
  output logic              rf_inv_en,
  output logic [REG_AW-1:0] rf_inv_addr,

  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,

  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_rs1_data,
  output logic [XLEN-1:0]   out_rs2_data,
  output logic [XLEN-1:0]   out_imm,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_rd_en,
  output logic [REG_AW-1:0] out_rd,
  output logic [15:0]       stall_cnt
);

  of_state_t       state;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic            hazard1;
  logic            hazard2;
  logic            hazard;
  logic            accept;

  assign rf_rd0_en   = in_valid & in_rs1_en;
  assign rf_rd1_en   = in_valid & in_rs2_en;
  assign rf_rd0_addr = in_rs1;
  assign rf_rd1_addr = in_rs2;

  of_bypass u_bypass1 (
    .src_en   (in_rs1_en),
    .src_addr (in_rs1),
    .rf_data  (rf_rd0_data),
    .rf_dirty (rf_rd0_dirty),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .operand  (operand1),
    .hazard   (hazard1)
  );

  of_bypass u_bypass2 (
    .src_en   (in_rs2_en),
    .src_addr (in_rs2),
    .rf_data  (rf_rd1_data),
    .rf_dirty (rf_rd1_dirty),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .operand  (operand2),
    .hazard   (hazard2)
  );

  // in_ready is built from hazard and the output slot only, never in_valid.
  assign hazard    = hazard1 | hazard2;
  assign out_valid = (state == FULL);
  assign in_ready  = !hazard && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready && reset_n;

  assign rf_inv_en   = accept && in_rd_en && (in_rd != '0);
  assign rf_inv_addr = in_rd;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= EMPTY;
      out_pc       <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_imm      <= '0;
      out_ctrl     <= '0;
      out_rd_en    <= 1'b0;
      out_rd       <= '0;
      stall_cnt    <= '0;
    end else begin
      if (accept) begin
        state        <= FULL;
        out_pc       <= in_pc;
        out_rs1_data <= operand1;
        out_rs2_data <= operand2;
        out_imm      <= in_imm;
        out_ctrl     <= in_ctrl;
        out_rd_en    <= in_rd_en;
        out_rd       <= in_rd;
      end else if (out_ready) begin
        state <= EMPTY;
      end

      if (in_valid && hazard && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: a behavioural register file with pending
// bits supplies read data; expected operands are queued on accept and popped on transfer.
module tb_operand_fetch;

  localparam int CTRL_W = 16;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        rs1_en;
    logic [4:0]  rs1;
    logic        rs2_en;
    logic [4:0]  rs2;
    logic        rd_en;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [15:0] ctrl;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_ready;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [15:0] ctrl;
    logic        rd_en;
    logic [4:0]  rd;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid, in_ready;
  logic [31:0]       in_pc, in_imm;
  logic              in_rs1_en, in_rs2_en, in_rd_en;
  logic [4:0]        in_rs1, in_rs2, in_rd;
  logic [CTRL_W-1:0] in_ctrl;
  logic              rf_rd0_en, rf_rd1_en;
  logic [4:0]        rf_rd0_addr, rf_rd1_addr;
  logic [31:0]       rf_rd0_data, rf_rd1_data;
  logic              rf_rd0_dirty, rf_rd1_dirty;
  logic              rf_inv_en;
  logic [4:0]        rf_inv_addr;
  logic              wb_en;
  logic [4:0]        wb_addr;
  logic [31:0]       wb_data;
  logic              out_valid, out_ready;
  logic [31:0]       out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_rd_en;
  logic [4:0]        out_rd;
  logic [15:0]       stall_cnt;

  logic [31:0] regs  [32];
  logic        dirty [32];
  exp_t        sb_q [$];
  int          total = 0;
  int          passed = 0;
  int          stall_model = 0;

  always #5 clk = ~clk;

  operand_fetch #(.CTRL_W(CTRL_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd_en(in_rd_en), .in_rd(in_rd), .in_imm(in_imm), .in_ctrl(in_ctrl),
    .rf_rd0_en(rf_rd0_en), .rf_rd1_en(rf_rd1_en),
    .rf_rd0_addr(rf_rd0_addr), .rf_rd1_addr(rf_rd1_addr),
    .rf_rd0_data(rf_rd0_data), .rf_rd1_data(rf_rd1_data),
    .rf_rd0_dirty(rf_rd0_dirty), .rf_rd1_dirty(rf_rd1_dirty),
    .rf_inv_en(rf_inv_en), .rf_inv_addr(rf_inv_addr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
    .out_ctrl(out_ctrl), .out_rd_en(out_rd_en), .out_rd(out_rd),
    .stall_cnt(stall_cnt)
  );

  // Register file environment: writeback clears pending, invalidate (later) wins.
  assign rf_rd0_data  = regs[rf_rd0_addr];
  assign rf_rd1_data  = regs[rf_rd1_addr];
  assign rf_rd0_dirty = dirty[rf_rd0_addr];
  assign rf_rd1_dirty = dirty[rf_rd1_addr];

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        regs[i]  <= '0;
        dirty[i] <= 1'b0;
      end
    end else begin
      if (wb_en && wb_addr != 5'd0) begin
        regs[wb_addr]  <= wb_data;
        dirty[wb_addr] <= 1'b0;
      end
      if (rf_inv_en) dirty[rf_inv_addr] <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Architectural value of a source as seen this cycle, including same-cycle writeback.
  function automatic logic [31:0] src_value(input logic en, input logic [4:0] rs, input stim_t s);
    if (!en || rs == 5'd0) return 32'd0;
    if (s.wb_en && s.wb_addr == rs) return s.wb_data;
    return regs[rs];
  endfunction

  function automatic logic src_stalls(input logic en, input logic [4:0] rs, input stim_t s);
    return en && rs != 5'd0 && dirty[rs] && !(s.wb_en && s.wb_addr == rs);
  endfunction

  task automatic check_output(input stim_t s);
    logic hz, full, exp_ready, exp_inv;
    exp_t e;
    hz        = src_stalls(s.rs1_en, s.rs1, s) || src_stalls(s.rs2_en, s.rs2, s);
    full      = (sb_q.size() != 0);
    exp_ready = !hz && (!full || s.out_ready);
    exp_inv   = s.valid && exp_ready && s.rd_en && s.rd != 5'd0;
    check("out_valid", {31'd0, out_valid}, {31'd0, full});
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    check("rf_rd0_en", {31'd0, rf_rd0_en}, {31'd0, s.valid && s.rs1_en});
    check("rf_inv_en", {31'd0, rf_inv_en}, {31'd0, exp_inv});
    if (exp_inv) check("rf_inv_addr", {27'd0, rf_inv_addr}, {27'd0, s.rd});
    check("stall_cnt", {16'd0, stall_cnt}, stall_model);
    if (s.valid && hz && stall_model < 65535) stall_model++;
    if (s.valid && exp_ready) begin
      e.pc       = s.pc;
      e.rs1_data = src_value(s.rs1_en, s.rs1, s);
      e.rs2_data = src_value(s.rs2_en, s.rs2, s);
      e.imm      = s.imm;
      e.ctrl     = s.ctrl;
      e.rd_en    = s.rd_en;
      e.rd       = s.rd;
      sb_q.push_back(e);
    end
  endtask

  task automatic apply_stimulus(input stim_t s);
    @(negedge clk);
    in_valid  = s.valid;   in_pc     = s.pc;     in_imm  = s.imm; in_ctrl = s.ctrl;
    in_rs1_en = s.rs1_en;  in_rs1    = s.rs1;
    in_rs2_en = s.rs2_en;  in_rs2    = s.rs2;
    in_rd_en  = s.rd_en;   in_rd     = s.rd;
    wb_en     = s.wb_en;   wb_addr   = s.wb_addr; wb_data = s.wb_data;
    out_ready = s.out_ready;
    #1;
    check_output(s);
  endtask

  // Monitor: pops and compares whenever the stage hands over an instruction.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (reset_n === 1'b1 && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        $display("[TB] FAIL sb_unexpected: got out_valid=1, expected no pending entry");
      end else begin
        e = sb_q.pop_front();
        check("out_pc", out_pc, e.pc);
        check("out_rs1_data", out_rs1_data, e.rs1_data);
        check("out_rs2_data", out_rs2_data, e.rs2_data);
        check("out_imm", out_imm, e.imm);
        check("out_ctrl", {16'd0, out_ctrl}, {16'd0, e.ctrl});
        check("out_rd", {26'd0, out_rd_en, out_rd}, {26'd0, e.rd_en, e.rd});
      end
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '{valid: 1'b0, pc: 32'd0, rs1_en: 1'b0, rs1: 5'd0, rs2_en: 1'b0, rs2: 5'd0,
          rd_en: 1'b0, rd: 5'd0, imm: 32'd0, ctrl: 16'd0, wb_en: 1'b0, wb_addr: 5'd0,
          wb_data: 32'd0, out_ready: 1'b1};
    return s;
  endfunction

  function automatic stim_t wb(input logic [4:0] a, input logic [31:0] d);
    stim_t s;
    s = idle();
    s.wb_en = 1'b1; s.wb_addr = a; s.wb_data = d;
    return s;
  endfunction

  function automatic stim_t instr(input logic r1e, input logic [4:0] r1, input logic r2e,
                                  input logic [4:0] r2, input logic rde, input logic [4:0] rd);
    stim_t s;
    s = idle();
    s.valid = 1'b1; s.pc = $urandom; s.imm = $urandom; s.ctrl = 16'($urandom);
    s.rs1_en = r1e; s.rs1 = r1; s.rs2_en = r2e; s.rs2 = r2; s.rd_en = rde; s.rd = rd;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s = instr(1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
              1'($urandom), 5'($urandom_range(0, 7)));
    s.valid     = ($urandom_range(0, 3) != 0);
    s.wb_en     = ($urandom_range(0, 2) == 0);
    s.wb_addr   = 5'($urandom_range(0, 7));
    s.wb_data   = $urandom;
    s.out_ready = ($urandom_range(0, 3) != 0);
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; in_valid = 1'b1; in_rd_en = 1'b1; in_rd = 5'd7;
    in_rs1_en = 1'b0; in_rs2_en = 1'b0; wb_en = 1'b0; out_ready = 1'b0;
    #1;
    check("reset_inv_en", {31'd0, rf_inv_en}, 32'd0);
    @(negedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    check("reset_out_pc", out_pc, 32'd0);
    check("reset_out_rs1", out_rs1_data, 32'd0);
    check("reset_out_ctrl", {16'd0, out_ctrl}, 32'd0);
    sb_q.delete();
    stall_model = 0;
    reset_n = 1'b1; in_valid = 1'b0; in_rd_en = 1'b0;
  endtask

  initial begin
    stim_t s;
    reset_n = 1'b0;
    apply_stimulus(idle());
    do_reset();

    // Basic read of x3/x4.
    apply_stimulus(wb(5'd3, 32'h11));
    apply_stimulus(wb(5'd4, 32'h22));
    apply_stimulus(instr(1, 5'd3, 1, 5'd4, 0, 5'd0));
    apply_stimulus(idle());

    // Pending x5 stalls until its writeback, which is bypassed the same cycle.
    apply_stimulus(instr(0, 5'd0, 0, 5'd0, 1, 5'd5));
    s = instr(1, 5'd5, 0, 5'd0, 0, 5'd0);
    repeat (3) apply_stimulus(s);
    s.wb_en = 1'b1; s.wb_addr = 5'd5; s.wb_data = 32'hDEAD;
    apply_stimulus(s);

    // Destination x7 invalidated, then a reader of x7 waits for writeback.
    apply_stimulus(instr(0, 5'd0, 0, 5'd0, 1, 5'd7));
    s = instr(1, 5'd7, 1, 5'd3, 0, 5'd0);
    repeat (2) apply_stimulus(s);
    apply_stimulus(wb(5'd7, 32'h7777));
    apply_stimulus(s);

    // Output backpressure for 4 cycles, then back-to-back transfers.
    apply_stimulus(instr(1, 5'd4, 0, 5'd0, 0, 5'd0));
    s = instr(1, 5'd3, 0, 5'd0, 0, 5'd0);
    s.out_ready = 1'b0;
    repeat (4) apply_stimulus(s);
    s.out_ready = 1'b1;
    apply_stimulus(s);
    apply_stimulus(instr(0, 5'd0, 1, 5'd7, 0, 5'd0));
    apply_stimulus(idle());

    // x0 as destination and source, with a writeback addressed to x0.
    s = instr(1, 5'd0, 0, 5'd0, 1, 5'd0);
    s.wb_en = 1'b1; s.wb_addr = 5'd0; s.wb_data = 32'h55;
    apply_stimulus(s);
    apply_stimulus(idle());

    // Reset while full and stalled.
    apply_stimulus(instr(0, 5'd0, 0, 5'd0, 1, 5'd6));
    s = instr(1, 5'd6, 0, 5'd0, 0, 5'd0);
    s.out_ready = 1'b0;
    repeat (3) apply_stimulus(s);
    do_reset();

    repeat (3000) apply_stimulus(rand_stim());
    repeat (4) apply_stimulus(idle());

    // Saturate the stall counter on a never-written pending register.
    apply_stimulus(instr(0, 5'd0, 0, 5'd0, 1, 5'd9));
    s = instr(1, 5'd9, 0, 5'd0, 0, 5'd0);
    repeat (70000) apply_stimulus(s);
    apply_stimulus(idle());
    check("stall_saturated", {16'd0, stall_cnt}, 32'h0000FFFF);
    repeat (3) apply_stimulus(idle());
    check("sb_drained", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
